// File: rtl/uart_pkg.sv
// Shared definitions for the UART command responder: FSM states,
// command/flag bit positions and the inter-byte timeout calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B1,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_TX_START,
        ST_TX_WAIT
    } state_t;

    // Upper command byte is {rw, addr}; rw=1 means write.
    localparam int CMD_RW_BIT  = 7;

    // Sticky error flag bit positions.
    localparam int ERR_GAP     = 0;
    localparam int ERR_RD_TO   = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_W       = 3;

    // Inter-byte timeout in clk cycles: GAP_FRAMES frames of 10 bits each.
    function automatic int calc_gap_limit(input longint sys_clk_freq,
                                          input longint bps,
                                          input longint gap_frames);
        return int'((gap_frames * 10 * sys_clk_freq) / bps);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Loadable down-counter with an expiry strobe. Loading sets the count to
// LIMIT-1; while enabled it counts down and strobes expired in the cycle
// the count sits at zero, i.e. the LIMIT-th enabled cycle after a load.
module uart_gap_timer #(
    parameter int LIMIT = 8680,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LIMIT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Far-end responder: collects a two-byte command from the UART receiver,
// performs a register write or read, and returns read data via the UART
// transmitter. Errors are kept as sticky flags until reset.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 7,
    parameter int                    BPS          = 115_200,
    parameter int                    SYS_CLK_FREQ = 50_000_000,
    parameter int                    GAP_FRAMES   = 2,
    parameter int                    RD_TIMEOUT   = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA    = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_en,
    input  logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_rvalid,
    output logic                  busy,
    output logic [ERR_W-1:0]      err_flags
);

    localparam int GAP_LIMIT = calc_gap_limit(longint'(SYS_CLK_FREQ),
                                              longint'(BPS),
                                              longint'(GAP_FRAMES));

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ERR_W-1:0]      err_q, err_d;

    logic gap_load, gap_en, gap_exp;
    logic rd_load, rd_en, rd_exp;

    uart_gap_timer #(.LIMIT(GAP_LIMIT)) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .en      (gap_en),
        .expired (gap_exp)
    );

    uart_gap_timer #(.LIMIT(RD_TIMEOUT)) u_rd_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rd_load),
        .en      (rd_en),
        .expired (rd_exp)
    );

    // Next-state, datapath capture and timer control.
    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        gap_load = 1'b0;
        gap_en   = 1'b0;
        rd_load  = 1'b0;
        rd_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    hdr_d    = rx_data;
                    gap_load = 1'b1;
                    state_d  = ST_WAIT_B1;
                end
            end
            ST_WAIT_B1: begin
                gap_en = 1'b1;
                // A byte arriving in the expiry cycle still completes the command.
                if (rx_done) begin
                    addr_d  = hdr_q[ADDR_WIDTH-1:0];
                    wdata_d = rx_data;
                    state_d = hdr_q[CMD_RW_BIT] ? ST_WRITE : ST_READ;
                end else if (gap_exp) begin
                    err_d[ERR_GAP] = 1'b1;
                    hdr_d          = '0;
                    state_d        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                rd_load = 1'b1;
                if (reg_rvalid) begin
                    rdata_d = reg_rdata;
                    state_d = ST_TX_START;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rd_en = 1'b1;
                if (reg_rvalid) begin
                    rdata_d = reg_rdata;
                    state_d = ST_TX_START;
                end else if (rd_exp) begin
                    rdata_d          = ERR_RDATA;
                    err_d[ERR_RD_TO] = 1'b1;
                    state_d          = ST_TX_START;
                end
            end
            ST_TX_START: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bytes arriving while a command is executing are dropped.
        if (rx_done && (state_q != ST_IDLE) && (state_q != ST_WAIT_B1)) begin
            err_d[ERR_OVERRUN] = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = (state_q == ST_WRITE);
    assign reg_rd    = (state_q == ST_READ);
    assign tx_en     = (state_q == ST_TX_START);
    assign tx_data   = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_flags = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: table vectors, hand-written
// corner sequences and a randomized phase against a command-level model.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_done = 1'b0;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic [2:0] err_flags;

    uart_cmd_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_done    (tx_done),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .busy       (busy),
        .err_flags  (err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] dat;
        int         gap;       // idle cycles between the two bytes
        int         rvd;       // rvalid delay after reg_rd, -1 = never
        int         txd;       // tx_done delay after tx_en
        logic       exp_wr;
        logic [6:0] exp_addr;
        logic [7:0] exp_byte;  // write data or returned read byte
        logic [2:0] exp_err;
    } vec_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t tx_q[$];

    int cyc = 0;
    int rv_delay = -1;
    int tx_delay = 1;
    int rv_cnt = 0;
    int tx_cnt = 0;
    int td_cyc = 0;
    int last_rx_cyc = 0;
    logic [7:0] rv_val = 8'h00;
    logic [7:0] mem[128];
    logic [7:0] ref_mem[128];

    int n_checks = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus/UART slave and event monitor, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        reg_rvalid = 1'b0;
        tx_done    = 1'b0;
        if (rst_n) begin
            if (reg_wr) begin
                wr_q.push_back('{reg_addr, reg_wdata, cyc});
                mem[reg_addr] = reg_wdata;
            end
            if (reg_rd) rd_q.push_back('{reg_addr, 8'h00, cyc});
            if (tx_en)  tx_q.push_back('{7'h00, tx_data, cyc});
        end
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = rv_val;
            end
        end
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                td_cyc  = cyc;
            end
        end
        if (rst_n && reg_rd && rv_delay >= 0) begin
            if (rv_delay == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = mem[reg_addr];
            end else begin
                rv_cnt = rv_delay;
                rv_val = mem[reg_addr];
            end
        end
        if (rst_n && tx_en) tx_cnt = tx_delay;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one cycle; called at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_done     = 1'b1;
        last_rx_cyc = cyc;
        step();
        rx_done     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check($sformatf("%s.idle", tag), {31'd0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s.strobes", tag), {28'd0, tx_en, reg_wr, reg_rd, busy}, 32'd0);
        check($sformatf("%s.tx_data", tag), {24'd0, tx_data}, 32'd0);
        check($sformatf("%s.reg_addr", tag), {25'd0, reg_addr}, 32'd0);
        check($sformatf("%s.reg_wdata", tag), {24'd0, reg_wdata}, 32'd0);
        check($sformatf("%s.err", tag), {29'd0, err_flags}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nw0, nr0, nt0, dcyc, exp_tx_lat;
        nw0 = wr_q.size();
        nr0 = rd_q.size();
        nt0 = tx_q.size();
        rv_delay = v.rvd;
        tx_delay = v.txd;
        send_byte(v.hdr);
        repeat (v.gap) step();
        send_byte(v.dat);
        dcyc = last_rx_cyc;
        wait_idle(tag);
        if (v.exp_wr) begin
            check($sformatf("%s.wr_count", tag), wr_q.size() - nw0, 1);
            if (wr_q.size() > nw0) begin
                check($sformatf("%s.wr_addr", tag), {25'd0, wr_q[nw0].addr}, {25'd0, v.exp_addr});
                check($sformatf("%s.wr_data", tag), {24'd0, wr_q[nw0].data}, {24'd0, v.exp_byte});
                check($sformatf("%s.wr_lat", tag), wr_q[nw0].cyc - dcyc, 1);
            end
            check($sformatf("%s.rd_count", tag), rd_q.size() - nr0, 0);
            check($sformatf("%s.tx_count", tag), tx_q.size() - nt0, 0);
        end else begin
            exp_tx_lat = (v.rvd < 0) ? 1 + 256 : 1 + v.rvd + 1;
            check($sformatf("%s.wr_count", tag), wr_q.size() - nw0, 0);
            check($sformatf("%s.rd_count", tag), rd_q.size() - nr0, 1);
            if (rd_q.size() > nr0) begin
                check($sformatf("%s.rd_addr", tag), {25'd0, rd_q[nr0].addr}, {25'd0, v.exp_addr});
                check($sformatf("%s.rd_lat", tag), rd_q[nr0].cyc - dcyc, 1);
            end
            check($sformatf("%s.tx_count", tag), tx_q.size() - nt0, 1);
            if (tx_q.size() > nt0) begin
                check($sformatf("%s.tx_data", tag), {24'd0, tx_q[nt0].data}, {24'd0, v.exp_byte});
                check($sformatf("%s.tx_lat", tag), tx_q[nt0].cyc - dcyc, exp_tx_lat);
                check($sformatf("%s.busy_until_txdone", tag), cyc - td_cyc, 1);
            end
        end
        check($sformatf("%s.err", tag), {29'd0, err_flags}, {29'd0, v.exp_err});
        $display("[cyc %0d] %s: hdr=%02h dat=%02h %s addr=%02h byte=%02h err=%03b",
                 cyc, tag, v.hdr, v.dat, v.exp_wr ? "WR" : "RD", v.exp_addr, v.exp_byte, err_flags);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        int nw0, nr0, nt0, n;

        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h12] = 8'hA7;
        mem[8'h01] = 8'h6B;

        tbl[0] = '{8'h85, 8'h3C, 0, 0, 1, 1'b1, 7'h05, 8'h3C, 3'b000};
        tbl[1] = '{8'h12, 8'h00, 2, 3, 2, 1'b0, 7'h12, 8'hA7, 3'b000};
        tbl[2] = '{8'h05, 8'hFF, 0, 0, 1, 1'b0, 7'h05, 8'h3C, 3'b000};
        tbl[3] = '{8'hFF, 8'h5A, 1, 0, 1, 1'b1, 7'h7F, 8'h5A, 3'b000};
        tbl[4] = '{8'h7F, 8'h00, 0, 1, 3, 1'b0, 7'h7F, 8'h5A, 3'b000};
        tbl[5] = '{8'h80, 8'h00, 3, 0, 1, 1'b1, 7'h00, 8'h00, 3'b000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        $display("[cyc %0d] reset: outputs checked", cyc);
        rst_n = 1'b1;
        step();

        // Table vectors, back-to-back.
        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Second byte in the very cycle the gap timer expires: byte wins.
        v = '{8'h83, 8'h99, 8679, 0, 1, 1'b1, 7'h03, 8'h99, 3'b000};
        run_vec(v, "gap_edge");

        // Gap timeout: header alone.
        nw0 = wr_q.size();
        send_byte(8'h85);
        repeat (8679) step();
        check("gap.busy_before", {31'd0, busy}, 32'd1);
        check("gap.err_before", {29'd0, err_flags}, 32'd0);
        step();
        check("gap.busy_after", {31'd0, busy}, 32'd0);
        check("gap.err_after", {29'd0, err_flags}, 32'd1);
        check("gap.no_write", wr_q.size() - nw0, 0);
        $display("[cyc %0d] gap_timeout: hdr=85 err=%03b", cyc, err_flags);
        v = '{8'h01, 8'h00, 0, 2, 1, 1'b0, 7'h01, 8'h6B, 3'b001};
        run_vec(v, "after_gap");

        // Read timeout: rvalid never comes.
        v = '{8'h20, 8'h00, 0, -1, 2, 1'b0, 7'h20, 8'hEE, 3'b011};
        run_vec(v, "rd_timeout");

        // Overrun: byte arrives while waiting for tx_done.
        nw0 = wr_q.size();
        nr0 = rd_q.size();
        nt0 = tx_q.size();
        rv_delay = 0;
        tx_delay = 6;
        send_byte(8'h12);
        send_byte(8'h00);
        n = 0;
        while (tx_q.size() == nt0 && n < 50) begin
            step();
            n++;
        end
        check("ovr.tx_seen", tx_q.size() - nt0, 1);
        send_byte(8'h55);
        wait_idle("ovr");
        repeat (5) step();
        check("ovr.wr_count", wr_q.size() - nw0, 0);
        check("ovr.rd_count", rd_q.size() - nr0, 1);
        check("ovr.tx_count", tx_q.size() - nt0, 1);
        if (tx_q.size() > nt0) check("ovr.tx_data", {24'd0, tx_q[nt0].data}, 32'hA7);
        check("ovr.err", {29'd0, err_flags}, 32'd7);
        $display("[cyc %0d] overrun: dropped 55 err=%03b", cyc, err_flags);
        v = '{8'h84, 8'h11, 0, 0, 1, 1'b1, 7'h04, 8'h11, 3'b111};
        run_vec(v, "after_ovr");

        // Reset in the middle of a read.
        nt0 = tx_q.size();
        rv_delay = -1;
        tx_delay = 1;
        send_byte(8'h30);
        send_byte(8'h00);
        repeat (10) step();
        check("rstmid.busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rv_val = 8'h77;
        rv_cnt = 2;
        repeat (10) step();
        check("rstmid.no_tx", tx_q.size() - nt0, 0);
        check("rstmid.idle", {31'd0, busy}, 32'd0);
        $display("[cyc %0d] reset_mid_read: outputs cleared", cyc);

        // Randomized commands against the command-level model.
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int k = 0; k < 40; k++) begin
            v.hdr      = 8'($urandom);
            v.dat      = 8'($urandom);
            v.gap      = int'($urandom_range(0, 3));
            v.rvd      = int'($urandom_range(0, 6));
            v.txd      = int'($urandom_range(1, 4));
            v.exp_wr   = v.hdr[7];
            v.exp_addr = v.hdr[6:0];
            v.exp_err  = 3'b000;
            if (v.exp_wr) begin
                v.exp_byte          = v.dat;
                ref_mem[v.hdr[6:0]] = v.dat;
            end else begin
                v.exp_byte = ref_mem[v.hdr[6:0]];
            end
            run_vec(v, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
